term_uart_tx: RTL

TERM_UART_TX -- requirements
Module: term_uart_tx

---
 rtl/term_uart_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/term_uart_tx.sv
// Buffered UART transmitter: small byte FIFO feeding an 8N1 LSB-first serial FSM.
// Define TERM_UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module term_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_data_v,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

`ifdef TERM_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push, pop;
  logic [7:0]    head;

  // Serializer
  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end;
`ifdef TERM_UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign head  = mem[rd_ptr_q];

  // Fullness is judged on the pre-edge level, so a same-edge pop frees the slot.
  always_comb begin
    push     = i_data_v && (!full || pop);
    ovf_d    = i_data_v && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_data;
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // tx_d is the line level for the state being entered, keeping o_tx a pure flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef TERM_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef TERM_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef TERM_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef TERM_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef TERM_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef TERM_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef TERM_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign o_tx       = tx_q;
  assign o_overflow = ovf_q;
  assign o_level    = level_q;
  assign o_busy     = (state_q != S_IDLE) || !empty;

endmodule
